// File: rtl/al422_bam_hub75_multi.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | al422_bam_hub75_multi                                                    |
// | AL422 packet-stream reader driving an N_CH-channel HUB75 panel with BAM  |
// | OE timing and a stream watchdog.                                         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module al422_bam_hub75_multi #(
    parameter int N_CH      = 2,
    parameter int ROW_W     = 5,
    parameter int CNT_BYTES = 2,
    parameter int LAT_LEN   = 1,
    parameter int MAX_PIX   = 256
) (
    input  logic                in_clk,
    input  logic                in_nrst,
    input  logic [7:0]          in_data,
    output logic                al422_re_out,
    output logic                al422_nrst_out,
    output logic                led_clk_out,
    output logic                led_lat_out,
    output logic                led_oe_out,
    output logic [ROW_W-1:0]    led_row,
    output logic [3*N_CH-1:0]   rgb_out,
    output logic                err_overrun
);
    localparam int c_B     = (N_CH + 1) / 2;
    localparam int c_CNT_W = 8 * CNT_BYTES;
    localparam int c_GRP_W = $clog2(MAX_PIX + 1);
    localparam logic [3:0] c_HDR_LAST = 4'(2 * CNT_BYTES);
    localparam logic [3:0] c_B_LAST   = 4'(c_B - 1);
    localparam logic [3:0] c_LAT_LEN  = 4'(LAT_LEN);
    localparam logic [c_GRP_W-1:0] c_GRP_LAST = c_GRP_W'(MAX_PIX - 1);

    typedef enum logic [1:0] {S_HDR, S_LOAD, S_HOLD, S_WAIT} state_t;
    typedef enum logic [1:0] {OE_IDLE, OE_ON, OE_OFF, OE_DONE} oe_state_t;

    state_t                 r_state, w_state_next;
    oe_state_t              r_oe_state, w_oe_state_next;
    logic [3:0]             r_byte_cnt;
    logic [2*c_CNT_W-1:0]   r_pre, w_pre_next;
    logic [6*c_B-1:0]       r_stage, w_stage_next;
    logic [c_CNT_W-1:0]     r_oe_cnt, w_oe_cnt_next;
    logic [c_GRP_W-1:0]     r_grp;
    logic [ROW_W-1:0]       r_row;
    logic [3*N_CH-1:0]      r_rgb;
    logic [2:0]             r_pol;
    logic                   r_oe, w_oe_next, r_lat, r_clk;
    logic                   r_eob, r_eof, r_fifo_nrst, r_err;
    logic                   w_hdr_last, w_load_last, w_blk_end, w_oe_done, w_row_start;
    logic [c_CNT_W-1:0]     w_on, w_off, w_off_held;

    // Preloads arrive LSB first, so shift bytes in from the top.
    assign w_pre_next  = {in_data, r_pre[2*c_CNT_W-1:8]};
    assign w_on        = w_pre_next[c_CNT_W-1:0];
    assign w_off       = w_pre_next[2*c_CNT_W-1:c_CNT_W];
    assign w_off_held  = r_pre[2*c_CNT_W-1:c_CNT_W];
    assign w_hdr_last  = (r_state == S_HDR)  && (r_byte_cnt == c_HDR_LAST);
    assign w_load_last = (r_state == S_LOAD) && (r_byte_cnt == c_B_LAST);
    assign w_blk_end   = r_eob || r_eof || (r_grp == c_GRP_LAST);
    assign w_oe_done   = (r_oe_state == OE_DONE);

    always_comb begin
        w_stage_next = r_stage;
        for (int j = 0; j < c_B; j++) begin
            if (r_byte_cnt == 4'(j)) w_stage_next[6*j +: 6] = in_data[5:0];
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_row_start  = 1'b0;
        al422_re_out = 1'b1;
        case (r_state)
            S_HDR: begin
                al422_re_out = 1'b0;
                if (w_hdr_last) w_state_next = S_LOAD;
            end
            S_LOAD: begin
                al422_re_out = 1'b0;
                if (w_load_last) w_state_next = S_HOLD;
            end
            S_HOLD: begin
                if (!w_blk_end) begin
                    w_state_next = S_LOAD;
                end else if (w_oe_done) begin
                    w_state_next = S_HDR;
                    w_row_start  = 1'b1;
                end else begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_oe_done) begin
                    w_state_next = S_HDR;
                    w_row_start  = 1'b1;
                end
            end
            default: w_state_next = S_HDR;
        endcase
    end

    // OE sequencer: ON cycles high, OFF cycles low, then park in OE_DONE.
    always_comb begin
        w_oe_state_next = r_oe_state;
        w_oe_next       = r_oe;
        w_oe_cnt_next   = r_oe_cnt;
        if (w_row_start) begin
            w_oe_state_next = OE_IDLE;
            w_oe_next       = 1'b0;
        end else if (w_hdr_last) begin
            if (w_on != '0) begin
                w_oe_state_next = OE_ON;
                w_oe_next       = 1'b1;
                w_oe_cnt_next   = w_on - 1'b1;
            end else if (w_off != '0) begin
                w_oe_state_next = OE_OFF;
                w_oe_cnt_next   = w_off - 1'b1;
            end else begin
                w_oe_state_next = OE_DONE;
            end
        end else begin
            case (r_oe_state)
                OE_ON: begin
                    if (r_oe_cnt != '0) begin
                        w_oe_cnt_next = r_oe_cnt - 1'b1;
                    end else begin
                        w_oe_next = 1'b0;
                        if (w_off_held != '0) begin
                            w_oe_state_next = OE_OFF;
                            w_oe_cnt_next   = w_off_held - 1'b1;
                        end else begin
                            w_oe_state_next = OE_DONE;
                        end
                    end
                end
                OE_OFF: begin
                    if (r_oe_cnt != '0) w_oe_cnt_next = r_oe_cnt - 1'b1;
                    else                w_oe_state_next = OE_DONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge in_clk or negedge in_nrst) begin
        if (!in_nrst) begin
            r_state     <= S_HDR;
            r_oe_state  <= OE_IDLE;
            r_oe_cnt    <= '0;
            r_oe        <= 1'b0;
            r_lat       <= 1'b0;
            r_clk       <= 1'b0;
            r_pol       <= 3'b001;
            r_byte_cnt  <= '0;
            r_pre       <= '0;
            r_stage     <= '0;
            r_grp       <= '0;
            r_row       <= '0;
            r_rgb       <= '0;
            r_eob       <= 1'b0;
            r_eof       <= 1'b0;
            r_fifo_nrst <= 1'b1;
            r_err       <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_oe_state <= w_oe_state_next;
            r_oe       <= w_oe_next;
            r_oe_cnt   <= w_oe_cnt_next;
            // Panel strobes are registered so they line up with row/polarity updates.
            r_lat      <= (r_state == S_HDR) && (r_byte_cnt < c_LAT_LEN);
            r_clk      <= (r_state == S_HOLD);
            case (r_state)
                S_HDR: begin
                    if (r_byte_cnt == '0) begin
                        r_row <= in_data[ROW_W-1:0];
                        r_pol <= in_data[7:5];
                    end else begin
                        r_pre <= w_pre_next;
                    end
                    r_byte_cnt <= w_hdr_last ? 4'd0 : r_byte_cnt + 4'd1;
                end
                S_LOAD: begin
                    r_stage <= w_stage_next;
                    if (w_load_last) begin
                        r_rgb      <= w_stage_next[3*N_CH-1:0];
                        r_eob      <= in_data[6];
                        r_eof      <= in_data[7];
                        r_byte_cnt <= '0;
                        if (in_data[7]) r_fifo_nrst <= 1'b0;
                    end else begin
                        r_byte_cnt <= r_byte_cnt + 4'd1;
                    end
                end
                S_HOLD: begin
                    r_grp <= r_grp + 1'b1;
                    if ((r_grp == c_GRP_LAST) && !r_eob && !r_eof) r_err <= 1'b1;
                end
                default: ;
            endcase
            if (w_row_start) begin
                r_grp       <= '0;
                r_fifo_nrst <= 1'b1;
            end
        end
    end

    assign led_oe_out     = r_oe  ^ r_pol[0];
    assign led_lat_out    = r_lat ^ r_pol[1];
    assign led_clk_out    = r_clk ^ r_pol[2];
    assign led_row        = r_row;
    assign rgb_out        = r_rgb;
    assign err_overrun    = r_err;
    assign al422_nrst_out = in_nrst & r_fifo_nrst;
endmodule
`default_nettype wire

// File: tb/tb_al422_bam_hub75_multi.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_al422_bam_hub75_multi                                                 |
// | Directed bench: AL422 byte-stream model feeding the HUB75 driver.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_al422_bam_hub75_multi;
    localparam int c_N_CH   = 3;
    localparam int c_ROW_W  = 5;
    localparam int c_MEM_SZ = 52;

    logic                    in_clk = 1'b0;
    logic                    in_nrst = 1'b0;
    logic [7:0]              in_data;
    logic                    al422_re_out, al422_nrst_out;
    logic                    led_clk_out, led_lat_out, led_oe_out, err_overrun;
    logic [c_ROW_W-1:0]      led_row;
    logic [3*c_N_CH-1:0]     rgb_out;

    int n_cmp = 0;
    int n_bad = 0;
    int r_ptr;
    int r_base = 0;
    logic r_take = 1'b0;

    // pkt1 row3 oe/lat inv ON4 OFF2 3 groups EOB | pkt2 row5 lat inv ON0 OFF0 EOF
    // pkt3 row1 clk inv ON1 OFF1 4 groups no EOB | pkt4 row2 ON2 OFF0 EOB
    // pkt5 row4 ON3 (cut by reset) | pkt6 row7 ON0 OFF0 EOB
    logic [7:0] r_mem [0:c_MEM_SZ-1] = '{
        8'h63, 8'h04, 8'h00, 8'h02, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h3F, 8'h7F,
        8'h45, 8'h00, 8'h00, 8'h00, 8'h00, 8'h12, 8'h80,
        8'h81, 8'h01, 8'h00, 8'h01, 8'h00, 8'h09, 8'h00, 8'h00, 8'h01, 8'h00, 8'h02,
        8'h00, 8'h03,
        8'h02, 8'h02, 8'h00, 8'h00, 8'h00, 8'h24, 8'h40,
        8'h04, 8'h03, 8'h00, 8'h00, 8'h00, 8'h3F, 8'h7F,
        8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h05, 8'h40
    };

    logic               a_re [0:63], a_oe [0:63], a_lat [0:63];
    logic               a_clk [0:63], a_nrst [0:63], a_err [0:63];
    logic [c_ROW_W-1:0] a_row [0:63];
    logic [3*c_N_CH-1:0] a_rgb [0:63];

    al422_bam_hub75_multi #(
        .N_CH(c_N_CH), .ROW_W(c_ROW_W), .CNT_BYTES(2), .LAT_LEN(3), .MAX_PIX(4)
    ) u_dut (
        .in_clk(in_clk), .in_nrst(in_nrst), .in_data(in_data),
        .al422_re_out(al422_re_out), .al422_nrst_out(al422_nrst_out),
        .led_clk_out(led_clk_out), .led_lat_out(led_lat_out), .led_oe_out(led_oe_out),
        .led_row(led_row), .rgb_out(rgb_out), .err_overrun(err_overrun)
    );

    always #5 in_clk = ~in_clk;

    assign in_data = (r_ptr < c_MEM_SZ) ? r_mem[r_ptr] : 8'h00;

    // FIFO model: a byte is consumed on each rising edge that sees RE low.
    always @(negedge in_clk) r_take = !al422_re_out;
    always @(posedge in_clk or negedge in_nrst) begin
        if (!in_nrst)    r_ptr <= r_base;
        else if (r_take) r_ptr <= r_ptr + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic capture(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge in_clk);
            a_re[k]   = al422_re_out;
            a_oe[k]   = led_oe_out;
            a_lat[k]  = led_lat_out;
            a_clk[k]  = led_clk_out;
            a_nrst[k] = al422_nrst_out;
            a_err[k]  = err_overrun;
            a_row[k]  = led_row;
            a_rgb[k]  = rgb_out;
        end
    endtask

    // Bit k-lo of the result is the chosen output during cycle k.
    function automatic logic [31:0] bits(input int sel, input int lo, input int hi);
        logic [31:0] v;
        v = '0;
        for (int k = lo; k <= hi; k++) begin
            case (sel)
                0:       v[k-lo] = a_re[k];
                1:       v[k-lo] = a_oe[k];
                2:       v[k-lo] = a_lat[k];
                3:       v[k-lo] = a_clk[k];
                4:       v[k-lo] = a_nrst[k];
                default: v[k-lo] = a_err[k];
            endcase
        end
        return v;
    endfunction

    initial begin
        repeat (3) @(posedge in_clk);
        #1;
        check("rst_ctl", 32'({led_oe_out, led_lat_out, led_clk_out, al422_re_out,
                              al422_nrst_out, err_overrun}), 32'b100000);
        check("rst_row", 32'(led_row), 32'h0);
        check("rst_rgb", 32'(rgb_out), 32'h0);
        in_nrst = 1'b1;
        capture(53);

        check("p1_re",    bits(0, 0, 14), 32'h2480);
        check("p1_row0",  32'(a_row[0]), 32'd0);
        check("p1_row",   32'(a_row[1]), 32'd3);
        check("p1_oe",    bits(1, 0, 13), 32'h3E1F);
        check("p1_lat",   bits(2, 0, 4),  32'h10);
        check("p1_clk",   bits(3, 0, 14), 32'h4900);
        check("p1_rgb0",  32'(a_rgb[6]),  32'h000);
        check("p1_rgb1",  32'(a_rgb[7]),  32'h001);
        check("p1_rgb2",  32'(a_rgb[10]), 32'h002);
        check("p1_rgb3",  32'(a_rgb[13]), 32'h1FF);
        check("p2_row",   32'(a_row[15]), 32'd5);
        check("p2_lat",   bits(2, 14, 18), 32'h11);
        check("p2_oe",    bits(1, 15, 21), 32'h0);
        check("p2_rgb",   32'(a_rgb[21]), 32'h012);
        check("eof_nrst", bits(4, 14, 23), 32'h37F);
        check("p3_lat",   bits(2, 22, 26), 32'h0F);
        check("p3_oe",    bits(1, 26, 29), 32'h2);
        check("p3_clk",   bits(3, 23, 39), 32'hDB7F);
        check("p3_rgb1",  32'(a_rgb[29]), 32'h009);
        check("p3_rgb4",  32'(a_rgb[38]), 32'h0C0);
        check("wd_err",   bits(5, 38, 52), 32'h7FFE);
        check("p4_row",   32'(a_row[40]), 32'd2);
        check("p4_oe",    bits(1, 43, 46), 32'h6);
        check("p4_re",    bits(0, 44, 47), 32'h4);
        check("p5_row",   32'(a_row[48]), 32'd4);
        check("p4_rgb",   32'(a_rgb[52]), 32'h024);

        // Abort in the middle of the first S_LOAD cycle of pkt5.
        #1;
        r_base  = 45;
        in_nrst = 1'b0;
        #1;
        check("mid_rst_ctl", 32'({led_oe_out, led_lat_out, led_clk_out, al422_re_out,
                                  al422_nrst_out, err_overrun}), 32'b100000);
        check("mid_rst_row", 32'(led_row), 32'h0);
        check("mid_rst_rgb", 32'(rgb_out), 32'h0);

        @(posedge in_clk);
        #1;
        in_nrst = 1'b1;
        capture(9);
        check("p6_row",  32'(a_row[1]), 32'd7);
        check("p6_lat",  bits(2, 0, 4), 32'h0E);
        check("p6_oe",   bits(1, 1, 7), 32'h0);
        check("p6_rgb",  32'(a_rgb[7]), 32'h005);
        check("p6_hdr",  bits(0, 5, 8), 32'h4);
        check("p6_err",  32'(a_err[8]), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
